// File: rtl/branch_update_unit.sv
// Writer side of the branch predictor: queues predictions issued at fetch, and
// turns each execute resolution into a registered table update plus a mispredict pulse.
module branch_update_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int HIST_WIDTH  = 3,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  input  logic                  fetch_prediction,
  output logic                  fetch_ready,
  output logic [HIST_WIDTH-1:0] prev_history,
  output logic                  evict,
  input  logic                  resolve_valid,
  input  logic                  resolve_taken,
  output logic                  we,
  output logic [PC_WIDTH-1:0]   old_pc,
  output logic                  branch_taken,
  output logic [HIST_WIDTH-1:0] update_history,
  output logic                  mispredict
);

  localparam int NUM_ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH;
  localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
  localparam int CNT_WIDTH   = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(QUEUE_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic                  pred;
    logic [HIST_WIDTH-1:0] hist;
  } entry_t;

  entry_t                queue_mem [QUEUE_DEPTH];
  logic [HIST_WIDTH-1:0] hist      [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]  tag       [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tag_valid;

  logic [PTR_WIDTH-1:0]  head_ptr, tail_ptr;
  logic [CNT_WIDTH-1:0]  count;

  logic [INDEX_WIDTH-1:0] fetch_idx;
  logic [TAG_WIDTH-1:0]   fetch_tag;
  logic [INDEX_WIDTH-1:0] head_idx;
  entry_t                 head_entry;
  logic                   accept, push, pop, flush;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_idx    = fetch_pc[INDEX_WIDTH-1:0];
    fetch_tag    = fetch_pc[PC_WIDTH-1:INDEX_WIDTH];
    head_entry   = queue_mem[head_ptr];
    head_idx     = head_entry.pc[INDEX_WIDTH-1:0];
    fetch_ready  = (count != FULL_COUNT);
    accept       = fetch_valid && fetch_ready;
    prev_history = hist[fetch_idx];
    evict        = accept && (!tag_valid[fetch_idx] || (tag[fetch_idx] != fetch_tag));
    pop          = resolve_valid && (count != '0);
    flush        = pop && (resolve_taken != head_entry.pred);
    // A mispredict squashes everything younger, including a same-cycle fetch.
    push         = accept && !flush;
  end

  // NOTE: queue payload and tags carry no reset; count and tag_valid already mark them dead.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[tail_ptr] <= '{pc: fetch_pc, pred: fetch_prediction, hist: hist[fetch_idx]};
    end
    if (evict) begin
      tag[fetch_idx] <= fetch_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the later eviction write
  // to hist intentionally overrides a same-index resolve shift on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr       <= '0;
      tail_ptr       <= '0;
      count          <= '0;
      tag_valid      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        hist[i] <= '0;
      end
      we             <= 1'b0;
      mispredict     <= 1'b0;
      branch_taken   <= 1'b0;
      old_pc         <= '0;
      update_history <= '0;
    end else begin
      we         <= pop;
      mispredict <= flush;

      if (pop) begin
        old_pc         <= head_entry.pc;
        branch_taken   <= resolve_taken;
        update_history <= head_entry.hist;
        hist[head_idx] <= {hist[head_idx][HIST_WIDTH-2:0], resolve_taken};
      end

      if (evict) begin
        hist[fetch_idx]      <= '0;
        tag_valid[fetch_idx] <= 1'b1;
      end

      if (flush) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (push) tail_ptr <= tail_ptr + 1'b1;
        if (pop)  head_ptr <= head_ptr + 1'b1;
        count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
// Directed bench for branch_update_unit: hand-computed expectations checked
// with immediate assertions, ending in one summary line.
module tb_branch_update_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_valid;
  logic [9:0] fetch_pc;
  logic       fetch_prediction;
  logic       fetch_ready;
  logic [2:0] prev_history;
  logic       evict;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       we;
  logic [9:0] old_pc;
  logic       branch_taken;
  logic [2:0] update_history;
  logic       mispredict;

  int checks = 0;
  int errors = 0;

  branch_update_unit dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_prediction (fetch_prediction),
    .fetch_ready      (fetch_ready),
    .prev_history     (prev_history),
    .evict            (evict),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .we               (we),
    .old_pc           (old_pc),
    .branch_taken     (branch_taken),
    .update_history   (update_history),
    .mispredict       (mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; combinational outputs are checked at posedge+2.
  task automatic drive(input logic fv, input logic [9:0] pc, input logic pred,
                       input logic rv, input logic rt);
    fetch_valid      = fv;
    fetch_pc         = pc;
    fetch_prediction = pred;
    resolve_valid    = rv;
    resolve_taken    = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fetch_valid   = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] pc, input logic pred);
    drive(1'b1, pc, pred, 1'b0, 1'b0);
    tick();
  endtask

  task automatic resolve_expect(input string tag, input logic rt, input logic [9:0] exp_pc,
                                input logic [2:0] exp_hist, input logic exp_mis);
    drive(1'b0, 10'h000, 1'b0, 1'b1, rt);
    tick();
    check({tag, "_we"},   we,             1);
    check({tag, "_pc"},   old_pc,         exp_pc);
    check({tag, "_bt"},   branch_taken,   rt);
    check({tag, "_hist"}, update_history, exp_hist);
    check({tag, "_mis"},  mispredict,     exp_mis);
  endtask

  task automatic peek_hist(input string tag, input logic [9:0] pc, input logic [2:0] exp);
    drive(1'b0, pc, 1'b0, 1'b0, 1'b0);
    check({tag, "_prev"},  prev_history, exp);
    check({tag, "_evict"}, evict,        0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    fetch_valid = 1'b0; fetch_pc = '0; fetch_prediction = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    tick();
    tick();
    check("rst_ready", fetch_ready,    1);
    check("rst_we",    we,             0);
    check("rst_mis",   mispredict,     0);
    check("rst_bt",    branch_taken,   0);
    check("rst_pc",    old_pc,         0);
    check("rst_hist",  update_history, 0);
    rst = 1'b1;

    // First fetch to an untagged index evicts; a taken resolve of a not-taken prediction mispredicts.
    drive(1'b1, 10'h013, 1'b0, 1'b0, 1'b0);
    check("t1_evict", evict,        1);
    check("t1_prev",  prev_history, 0);
    tick();
    resolve_expect("t1_res", 1'b1, 10'h013, 3'b000, 1'b1);
    peek_hist("t1_h3", 10'h013, 3'b001);
    tick();
    check("t1_we_drop",  we,         0);
    check("t1_mis_drop", mispredict, 0);

    // Four back-to-back fetches snapshot history before any resolve.
    drive(1'b1, 10'h005, 1'b1, 1'b0, 1'b0);
    check("t2_evict0", evict, 1);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 10'h005, 1'b1, 1'b0, 1'b0);
      check("t2_evictn", evict, 0);
      check("t2_prevn",  prev_history, 0);
      tick();
    end
    check("t2_full", fetch_ready, 0);
    for (int i = 0; i < 4; i++) resolve_expect("t2_res", 1'b1, 10'h005, 3'b000, 1'b0);
    drive(1'b1, 10'h005, 1'b1, 1'b0, 1'b0);
    check("t2_prev5",  prev_history, 3'b111);
    check("t2_evict5", evict,        0);
    tick();
    resolve_expect("t2_res5", 1'b1, 10'h005, 3'b111, 1'b0);

    // Full queue rejects a fetch even while popping.
    for (int i = 0; i < 4; i++) fetch(10'h005, 1'b1);
    drive(1'b1, 10'h006, 1'b1, 1'b1, 1'b1);
    check("t3_ready_full", fetch_ready, 0);
    check("t3_no_evict",   evict,       0);
    tick();
    check("t3_we",         we,          1);
    check("t3_ready_back", fetch_ready, 1);
    for (int i = 0; i < 3; i++) resolve_expect("t3_drain", 1'b1, 10'h005, 3'b111, 1'b0);
    drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
    tick();
    check("t3_empty_we", we, 0);

    // Mispredict flushes the queue and the same-cycle fetch.
    fetch(10'h021, 1'b1);
    fetch(10'h022, 1'b1);
    drive(1'b1, 10'h023, 1'b1, 1'b1, 1'b0);
    check("t4_evict", evict, 1);
    tick();
    check("t4_we",   we,             1);
    check("t4_mis",  mispredict,     1);
    check("t4_pc",   old_pc,         10'h021);
    check("t4_bt",   branch_taken,   0);
    check("t4_hist", update_history, 0);
    check("t4_ready", fetch_ready,   1);
    drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
    tick();
    check("t4_flushed_we", we, 0);
    drive(1'b1, 10'h023, 1'b0, 1'b0, 1'b0);
    check("t4_tag_kept", evict, 0);
    tick();
    resolve_expect("t4_res", 1'b0, 10'h023, 3'b000, 1'b0);

    // Build hist[2]=101 for pc 0x012, then alias it with 0x032.
    fetch(10'h012, 1'b1);
    resolve_expect("t5_a", 1'b1, 10'h012, 3'b000, 1'b0);
    fetch(10'h012, 1'b0);
    resolve_expect("t5_b", 1'b0, 10'h012, 3'b001, 1'b0);
    fetch(10'h012, 1'b1);
    resolve_expect("t5_c", 1'b1, 10'h012, 3'b010, 1'b0);
    peek_hist("t5_h2", 10'h012, 3'b101);
    fetch(10'h012, 1'b1);
    drive(1'b1, 10'h032, 1'b0, 1'b0, 1'b0);
    check("t5_evict", evict,        1);
    check("t5_prev",  prev_history, 3'b101);
    tick();
    peek_hist("t5_cleared", 10'h032, 3'b000);
    resolve_expect("t5_pending", 1'b1, 10'h012, 3'b101, 1'b0);
    drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
    tick();
    check("t5_alias_we", we,     1);
    check("t5_alias_pc", old_pc, 10'h032);

    // Reset mid-operation drops queued entries and clears histories.
    for (int i = 0; i < 3; i++) fetch(10'h005, 1'b1);
    rst = 1'b0;
    drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
    tick();
    check("t6_rst_we", we, 0);
    rst = 1'b1;
    drive(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
    tick();
    check("t6_post_we",    we,          0);
    check("t6_post_ready", fetch_ready, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 10'(i), 1'b0, 1'b0, 1'b0);
      check("t6_hist_zero", prev_history, 0);
    end
    drive(1'b1, 10'h005, 1'b1, 1'b0, 1'b0);
    check("t6_tag_invalid", evict, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
